// File: rtl/dmem_if.sv
// Data memory access bundle: byte-addressed read/store request lines plus registered status.
// Reads are free-running every cycle; there is no backpressure (out_ready only gates acceptance).
interface dmem_if #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16
);
  logic [DMEM_ADDR_WIDTH-1:0] in_mem_rd_addr;
  logic                       in_mem_rd_byte;
  logic                       in_mem_rd_signed;
  logic [DMEM_ADDR_WIDTH-1:0] in_mem_wr_addr;
  logic [DMEM_WORD_WIDTH-1:0] in_mem_wr_word;
  logic                       in_mem_write_en;
  logic                       in_mem_wr_byte;
  logic [DMEM_WORD_WIDTH-1:0] out_mem_rd_word;
  logic                       out_ready;
  logic                       out_err;
  logic [7:0]                 out_err_cnt;

  modport master (
    output in_mem_rd_addr, in_mem_rd_byte, in_mem_rd_signed,
    output in_mem_wr_addr, in_mem_wr_word, in_mem_write_en, in_mem_wr_byte,
    input  out_mem_rd_word, out_ready, out_err, out_err_cnt
  );

  modport slave (
    input  in_mem_rd_addr, in_mem_rd_byte, in_mem_rd_signed,
    input  in_mem_wr_addr, in_mem_wr_word, in_mem_write_en, in_mem_wr_byte,
    output out_mem_rd_word, out_ready, out_err, out_err_cnt
  );
endinterface

// File: rtl/dmem.sv
// 16-bit byte-addressable data memory with self-clearing after reset; 1-cycle write-first reads.
// No backpressure: accesses are ignored until the clear sweep finishes and out_ready is high.
module dmem #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16
) (
  input logic   clock,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int IDX_W = DMEM_ADDR_WIDTH - 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam int HI_W  = DMEM_WORD_WIDTH - 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]                 state;
  logic [IDX_W-1:0]           clr_idx;
  logic [DMEM_WORD_WIDTH-1:0] mem [DEPTH];

  logic [DMEM_WORD_WIDTH-1:0] rd_word_q;
  logic                       ready_q;
  logic                       err_q;
  logic [7:0]                 err_cnt_q;

  logic [IDX_W-1:0]           rd_idx;
  logic [IDX_W-1:0]           wr_idx;
  logic                       rd_lane;
  logic                       wr_lane;
  logic                       is_ready;
  logic                       clr_last;
  logic                       wr_misalign;
  logic                       rd_misalign;
  logic                       wr_ok;
  logic                       err_now;
  logic [DMEM_WORD_WIDTH-1:0] wr_cur;
  logic [DMEM_WORD_WIDTH-1:0] wr_merged;
  logic [DMEM_WORD_WIDTH-1:0] rd_raw;
  logic [7:0]                 rd_byte_sel;
  logic [DMEM_WORD_WIDTH-1:0] rd_next;

  assign rd_idx   = bus.in_mem_rd_addr[DMEM_ADDR_WIDTH-1:1];
  assign wr_idx   = bus.in_mem_wr_addr[DMEM_ADDR_WIDTH-1:1];
  assign rd_lane  = bus.in_mem_rd_addr[0];
  assign wr_lane  = bus.in_mem_wr_addr[0];
  assign is_ready = (state == ST_READY);
  assign clr_last = &clr_idx;

  // Only word accesses can be misaligned; byte lanes are always legal.
  assign wr_misalign = bus.in_mem_write_en && !bus.in_mem_wr_byte && wr_lane;
  assign rd_misalign = !bus.in_mem_rd_byte && rd_lane;
  assign wr_ok       = is_ready && bus.in_mem_write_en && !wr_misalign;
  assign err_now     = is_ready && (wr_misalign || rd_misalign);

  assign wr_cur = mem[wr_idx];

  always_comb begin
    wr_merged = bus.in_mem_wr_word;
    if (bus.in_mem_wr_byte) begin
      if (wr_lane) begin
        wr_merged = {bus.in_mem_wr_word[7:0], wr_cur[7:0]};
      end else begin
        wr_merged = {wr_cur[DMEM_WORD_WIDTH-1:8], bus.in_mem_wr_word[7:0]};
      end
    end
  end

  // Write-first: a same-cycle store to the read word is forwarded, byte merge included.
  assign rd_raw      = (wr_ok && (wr_idx == rd_idx)) ? wr_merged : mem[rd_idx];
  assign rd_byte_sel = rd_lane ? rd_raw[15:8] : rd_raw[7:0];

  always_comb begin
    rd_next = '0;
    if (bus.in_mem_rd_byte) begin
      rd_next = {{HI_W{bus.in_mem_rd_signed & rd_byte_sel[7]}}, rd_byte_sel};
    end else if (!rd_misalign) begin
      rd_next = rd_raw;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_CLEAR;
      clr_idx   <= '0;
      rd_word_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      case (state)
        ST_CLEAR: begin
          rd_word_q <= '0;
          err_q     <= 1'b0;
          if (clr_last) begin
            state   <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: begin
          rd_word_q <= rd_next;
          err_q     <= err_now;
          if (err_now && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  // Array has no reset; the clear sweep zeroes it one word per cycle.
  always_ff @(posedge clock) begin
    if (!is_ready) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_idx] <= wr_merged;
    end
  end

  assign bus.out_mem_rd_word = rd_word_q;
  assign bus.out_ready       = ready_q;
  assign bus.out_err         = err_q;
  assign bus.out_err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_dmem.sv
// Directed + randomized bench for dmem against an array-based reference model.
module tb_dmem;
  localparam int AW    = 12;
  localparam int DEPTH = 2048;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] ref_mem [DEPTH];
  int          ref_cnt;

  always #5 clock = ~clock;

  dmem_if #(.DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(16)) bus ();

  dmem #(.DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_mem_rd_addr   = '0;
    bus.in_mem_rd_byte   = 1'b0;
    bus.in_mem_rd_signed = 1'b0;
    bus.in_mem_wr_addr   = '0;
    bus.in_mem_wr_word   = '0;
    bus.in_mem_write_en  = 1'b0;
    bus.in_mem_wr_byte   = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    ref_cnt = 0;
  endtask

  // One READY-state cycle: drive, advance the model (store then read), check outputs.
  task automatic cyc(input string tag, input logic [11:0] ra, input logic rb, input logic rs,
                     input logic we, input logic [11:0] wa, input logic [15:0] wd, input logic wb);
    logic [15:0] exp_rd;
    logic [15:0] w;
    logic [7:0]  b;
    logic        exp_err;
    bus.in_mem_rd_addr   = ra;
    bus.in_mem_rd_byte   = rb;
    bus.in_mem_rd_signed = rs;
    bus.in_mem_wr_addr   = wa;
    bus.in_mem_wr_word   = wd;
    bus.in_mem_write_en  = we;
    bus.in_mem_wr_byte   = wb;
    exp_err = (we && !wb && wa[0]) || (!rb && ra[0]);
    if (we && (wb || !wa[0])) begin
      if (!wb) ref_mem[wa / 2] = wd;
      else if (wa[0]) ref_mem[wa / 2][15:8] = wd[7:0];
      else ref_mem[wa / 2][7:0] = wd[7:0];
    end
    w = ref_mem[ra / 2];
    if (rb) begin
      b = ra[0] ? w[15:8] : w[7:0];
      exp_rd = (rs && b[7]) ? (16'hFF00 | 16'(b)) : 16'(b);
    end else begin
      exp_rd = ra[0] ? 16'h0000 : w;
    end
    if (exp_err && ref_cnt < 255) ref_cnt++;
    tick();
    chk({tag, "_rd"}, 32'(bus.out_mem_rd_word), 32'(exp_rd));
    chk({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
    chk({tag, "_cnt"}, 32'(bus.out_err_cnt), 32'(ref_cnt));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.out_ready && n < 5000) begin
      tick();
      n++;
      chk({tag, "_clr_rd"}, 32'(bus.out_mem_rd_word), 32'h0);
      chk({tag, "_clr_err"}, 32'(bus.out_err), 32'h0);
    end
    chk({tag, "_edges"}, 32'(n), 32'd2048);
    idle_inputs();
  endtask

  initial begin
    logic [11:0] ra, wa;
    logic        rb, wb;
    idle_inputs();
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 32'(bus.out_ready), 32'h0);
    chk("rst_rd", 32'(bus.out_mem_rd_word), 32'h0);
    chk("rst_err", 32'(bus.out_err), 32'h0);
    chk("rst_cnt", 32'(bus.out_err_cnt), 32'h0);

    // Stores and misaligned reads during the clear sweep must be ignored.
    bus.in_mem_write_en = 1'b1;
    bus.in_mem_wr_addr  = 12'h040;
    bus.in_mem_wr_word  = 16'h1111;
    bus.in_mem_rd_addr  = 12'h003;
    reset = 1'b1;
    wait_ready("boot");
    chk("boot_cnt", 32'(bus.out_err_cnt), 32'h0);

    for (int a = 0; a < DEPTH; a++) cyc("scan", 12'(a * 2), 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0);
    cyc("clr_store", 12'h040, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0);
    chk("clr_store_const", 32'(bus.out_mem_rd_word), 32'h0000);

    cyc("beef_wr", 12'h000, 1'b0, 1'b0, 1'b1, 12'h010, 16'hBEEF, 1'b0);
    cyc("beef_rd", 12'h010, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0);
    chk("beef_word", 32'(bus.out_mem_rd_word), 32'hBEEF);
    cyc("beef_s", 12'h011, 1'b1, 1'b1, 1'b0, 12'h0, 16'h0, 1'b0);
    chk("beef_signed", 32'(bus.out_mem_rd_word), 32'hFFBE);
    cyc("beef_u", 12'h010, 1'b1, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0);
    chk("beef_unsigned", 32'(bus.out_mem_rd_word), 32'h00EF);

    cyc("m_wr", 12'h000, 1'b0, 1'b0, 1'b1, 12'h020, 16'h1234, 1'b0);
    cyc("m_byte", 12'h020, 1'b0, 1'b0, 1'b1, 12'h021, 16'hC35A, 1'b1);
    chk("merge_wfirst", 32'(bus.out_mem_rd_word), 32'h5A34);
    cyc("m_rd", 12'h020, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0);
    chk("merge_later", 32'(bus.out_mem_rd_word), 32'h5A34);

    cyc("mis_pre", 12'h000, 1'b0, 1'b0, 1'b1, 12'h030, 16'h7777, 1'b0);
    cyc("mis_wr", 12'h030, 1'b0, 1'b0, 1'b1, 12'h031, 16'hAAAA, 1'b0);
    chk("mis_wr_err", 32'(bus.out_err), 32'h1);
    chk("mis_wr_cnt", 32'(bus.out_err_cnt), 32'h1);
    cyc("mis_chk", 12'h030, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0);
    chk("mis_unchanged", 32'(bus.out_mem_rd_word), 32'h7777);
    chk("mis_pulse_end", 32'(bus.out_err), 32'h0);
    cyc("mis_both", 12'h033, 1'b0, 1'b0, 1'b1, 12'h035, 16'h5555, 1'b0);
    chk("mis_both_cnt", 32'(bus.out_err_cnt), 32'h2);

    for (int i = 0; i < 400; i++) begin
      ra = 12'($urandom_range(0, 63));
      wa = 12'($urandom_range(0, 63));
      rb = 1'($urandom);
      wb = 1'($urandom);
      if (!rb) ra[0] = ($urandom_range(0, 15) == 0);
      if (!wb) wa[0] = ($urandom_range(0, 15) == 0);
      cyc("rnd", ra, rb, 1'($urandom), 1'($urandom), wa, 16'($urandom), wb);
    end

    for (int i = 0; i < 300; i++) cyc("sat", 12'h001, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0);
    chk("sat_cnt", 32'(bus.out_err_cnt), 32'd255);

    // Reset aborts READY, then again mid-sweep at index 1000.
    reset = 1'b0;
    #1;
    chk("rst2_cnt", 32'(bus.out_err_cnt), 32'h0);
    chk("rst2_ready", 32'(bus.out_ready), 32'h0);
    model_clear();
    tick();
    reset = 1'b1;
    repeat (1000) tick();
    chk("mid_ready", 32'(bus.out_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(bus.out_mem_rd_word), 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    chk("rel_ready", 32'(bus.out_ready), 32'h0);
    wait_ready("again");
    chk("again_cnt", 32'(bus.out_err_cnt), 32'h0);
    cyc("again_beef", 12'h010, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0);
    cyc("again_top", 12'hFFE, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
